// File: rtl/display_pkg.sv
// Shared types for the display frame scheduler: FSM states, latched frame geometry,
// and a widening add so that line/frame totals never wrap.
package display_pkg;

  localparam int W = 10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUF = 3'd1,
    S_LOAD     = 3'd2,
    S_ACTIVE   = 3'd3,
    S_HBLANK   = 3'd4,
    S_VBLANK   = 3'd5,
    S_END      = 3'd6
  } state_t;

  typedef struct packed {
    logic [W-1:0] hb;
    logic [W-1:0] vb;
    logic [W-1:0] aip;
    logic [W-1:0] ail;
  } size_t;

  function automatic logic [W:0] add_ext(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/display_pos_counter.sv
// Pixel/line position counter pair. Counters are one bit wider than the size fields so
// blanking positions past the active area never alias back onto it.
module display_pos_counter #(
  parameter int W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic [W:0] i_line_len,
  input  logic [W:0] i_frame_len,
  output logic [W:0] o_pixel,
  output logic [W:0] o_line,
  output logic       o_line_end,
  output logic       o_frame_end
);

  localparam logic [W:0] L_ONE = {{W{1'b0}}, 1'b1};

  logic [W:0] r_pixel;
  logic [W:0] r_line;

  assign o_line_end  = (r_pixel == i_line_len - L_ONE);
  assign o_frame_end = o_line_end && (r_line == i_frame_len - L_ONE);
  assign o_pixel     = r_pixel;
  assign o_line      = r_line;

  // The line count parks on its last value at frame end; LOAD clears it for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel <= '0;
      r_line  <= '0;
    end else if (i_clear) begin
      r_pixel <= '0;
      r_line  <= '0;
    end else if (i_en) begin
      if (o_line_end) begin
        r_pixel <= '0;
        if (!o_frame_end) r_line <= r_line + L_ONE;
      end else begin
        r_pixel <= r_pixel + L_ONE;
      end
    end
  end

endmodule

// File: rtl/display_frame_sched.sv
// Frame scheduler: picks a full ping-pong buffer, runs frame timing from the latched
// blanking/active sizes, and releases the buffer when the frame ends.
module display_frame_sched
  import display_pkg::*;
#(
  parameter int W = display_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic [W-1:0] HBOut_PD,
  input  logic [W-1:0] VBOut_PD,
  input  logic [W-1:0] AIPOut_PD,
  input  logic [W-1:0] AILOut_PD,
  input  logic         Buf0Empty,
  input  logic         Buf1Empty,
  output logic         BufSel,
  output logic         BufDone,
  output logic         CSDisplay,
  output logic         readFrame,
  output logic         FrameReadResetLine,
  output logic         FrameReadIncLine,
  output logic [W-1:0] PixelCnt,
  output logic [W-1:0] LineCnt,
  output logic         FrameDone,
  output logic         Underrun,
  output logic         CfgErr,
  output logic [2:0]   o_dbg_state
);

  localparam logic [W:0] L_ONE = {{W{1'b0}}, 1'b1};

  state_t     r_state;
  state_t     w_next;
  state_t     w_eol_next;
  size_t      r_size;
  logic       r_pick;
  logic       r_buf_sel;
  logic       r_last_sel;
  logic       r_underrun;
  logic       r_cfg_err;
  logic       r_frame_seen;

  logic       w_cfg_err;
  logic       w_alt_full;
  logic       w_same_full;
  logic [W:0] w_line_len;
  logic [W:0] w_frame_len;
  logic [W:0] w_pixel;
  logic [W:0] w_line;
  logic       w_line_end;
  logic       w_frame_end;
  logic       w_pix_last_act;
  logic       w_more_lines;
  logic       w_cnt_en;

  assign w_cfg_err      = (AIPOut_PD == '0) || (AILOut_PD == '0);
  // lastSel starts at 1, so the "other" buffer on the first frame is buffer 0.
  assign w_alt_full     = r_last_sel ? !Buf0Empty : !Buf1Empty;
  assign w_same_full    = r_last_sel ? !Buf1Empty : !Buf0Empty;
  assign w_line_len     = add_ext(r_size.aip, r_size.hb);
  assign w_frame_len    = add_ext(r_size.ail, r_size.vb);
  assign w_pix_last_act = (w_pixel == ({1'b0, r_size.aip} - L_ONE));
  assign w_more_lines   = (w_line < ({1'b0, r_size.ail} - L_ONE));
  assign w_cnt_en       = (r_state == S_ACTIVE) || (r_state == S_HBLANK) || (r_state == S_VBLANK);
  assign w_eol_next     = w_more_lines ? S_ACTIVE : ((r_size.vb == '0) ? S_END : S_VBLANK);

  display_pos_counter #(.W(W)) u_pos (
    .clk         (clk),
    .rst_n       (reset),
    .i_clear     (r_state == S_LOAD),
    .i_en        (w_cnt_en),
    .i_line_len  (w_line_len),
    .i_frame_len (w_frame_len),
    .o_pixel     (w_pixel),
    .o_line      (w_line),
    .o_line_end  (w_line_end),
    .o_frame_end (w_frame_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (Start && !w_cfg_err) w_next = S_WAIT_BUF;
      S_WAIT_BUF: begin
        if (!Start || w_cfg_err)        w_next = S_IDLE;
        else if (w_alt_full || w_same_full) w_next = S_LOAD;
      end
      S_LOAD:     w_next = S_ACTIVE;
      S_ACTIVE:   if (w_pix_last_act) w_next = (r_size.hb == '0) ? w_eol_next : S_HBLANK;
      S_HBLANK:   if (w_line_end) w_next = w_eol_next;
      S_VBLANK:   if (w_frame_end) w_next = S_END;
      S_END:      w_next = Start ? S_WAIT_BUF : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    CSDisplay          = 1'b0;
    readFrame          = 1'b0;
    FrameReadResetLine = 1'b0;
    FrameReadIncLine   = 1'b0;
    BufDone            = 1'b0;
    FrameDone          = 1'b0;
    case (r_state)
      S_LOAD:   FrameReadResetLine = 1'b1;
      S_ACTIVE: begin
        CSDisplay        = 1'b1;
        readFrame        = 1'b1;
        FrameReadIncLine = w_pix_last_act;
      end
      S_HBLANK: CSDisplay = 1'b1;
      S_END: begin
        BufDone   = 1'b1;
        FrameDone = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_size       <= '0;
      r_pick       <= 1'b0;
      r_buf_sel    <= 1'b0;
      r_last_sel   <= 1'b1;
      r_underrun   <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_frame_seen <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_err;
      if (r_state == S_WAIT_BUF && Start && !w_cfg_err) begin
        if (w_alt_full)       r_pick <= ~r_last_sel;
        else if (w_same_full) r_pick <= r_last_sel;
        else if (r_frame_seen) r_underrun <= 1'b1;
      end
      if (r_state == S_LOAD) begin
        r_buf_sel <= r_pick;
        r_size    <= '{hb: HBOut_PD, vb: VBOut_PD, aip: AIPOut_PD, ail: AILOut_PD};
      end
      if (r_state == S_END) begin
        r_last_sel   <= r_buf_sel;
        r_frame_seen <= 1'b1;
      end
    end
  end

  assign BufSel      = r_buf_sel;
  assign Underrun    = r_underrun;
  assign CfgErr      = r_cfg_err;
  assign PixelCnt    = w_pixel[W-1:0];
  assign LineCnt     = w_line[W-1:0];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_display_frame_sched.sv
// Bench for display_frame_sched: per-frame expectations are derived from frame geometry
// and buffer-choice rules, then matched against what a monitor measures on the outputs.
module tb_display_frame_sched;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] HBOut_PD = '0;
  logic [W-1:0] VBOut_PD = '0;
  logic [W-1:0] AIPOut_PD = '0;
  logic [W-1:0] AILOut_PD = '0;
  logic         Buf0Empty = 1'b1;
  logic         Buf1Empty = 1'b1;
  logic         BufSel, BufDone, CSDisplay, readFrame;
  logic         FrameReadResetLine, FrameReadIncLine, FrameDone, Underrun, CfgErr;
  logic [W-1:0] PixelCnt, LineCnt;
  logic [2:0]   o_dbg_state;

  display_frame_sched #(.W(W)) dut (
    .clk                (clk),
    .reset              (reset),
    .Start              (Start),
    .HBOut_PD           (HBOut_PD),
    .VBOut_PD           (VBOut_PD),
    .AIPOut_PD          (AIPOut_PD),
    .AILOut_PD          (AILOut_PD),
    .Buf0Empty          (Buf0Empty),
    .Buf1Empty          (Buf1Empty),
    .BufSel             (BufSel),
    .BufDone            (BufDone),
    .CSDisplay          (CSDisplay),
    .readFrame          (readFrame),
    .FrameReadResetLine (FrameReadResetLine),
    .FrameReadIncLine   (FrameReadIncLine),
    .PixelCnt           (PixelCnt),
    .LineCnt            (LineCnt),
    .FrameDone          (FrameDone),
    .Underrun           (Underrun),
    .CfgErr             (CfgErr),
    .o_dbg_state        (o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  // Handshake: a frame is "presented" on the cycle FrameDone is high; the monitor pops exactly
  // one expectation per such cycle, and the driver pushes one per frame it asks for.
  typedef struct packed {
    logic        sel;
    logic [31:0] len;
    logic [31:0] incs;
    logic [31:0] reads;
    logic [31:0] cs;
    logic [31:0] gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_issued = 0;
  int   n_bufdone = 0;
  int   model_last_sel = 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference buffer choice: prefer the buffer not shown last, else repeat the last one.
  function automatic int pick_buf(input bit b0_full, input bit b1_full);
    int  other;
    bit  other_full;
    other      = 1 - model_last_sel;
    other_full = (other == 1) ? b1_full : b0_full;
    return other_full ? other : model_last_sel;
  endfunction

  task automatic set_sizes(input int hb, input int vb, input int aip, input int ail);
    HBOut_PD  = W'(hb);
    VBOut_PD  = W'(vb);
    AIPOut_PD = W'(aip);
    AILOut_PD = W'(ail);
  endtask

  task automatic issue(input int hb, input int vb, input int aip, input int ail,
                       input bit b0_full, input bit b1_full, input int gap);
    exp_t e;
    set_sizes(hb, vb, aip, ail);
    Buf0Empty = !b0_full;
    Buf1Empty = !b1_full;
    e.sel   = 1'(pick_buf(b0_full, b1_full));
    model_last_sel = int'(e.sel);
    e.len   = 32'(2 + (ail + vb) * (aip + hb));
    e.incs  = 32'(ail);
    e.reads = 32'(ail * aip);
    e.cs    = 32'(ail * (aip + hb));
    e.gap   = 32'(gap);
    exp_q.push_back(e);
    n_issued++;
  endtask

  task automatic issue_rand(input bit b0_full, input bit b1_full, input int gap);
    issue($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(1, 12),
          $urandom_range(1, 6), b0_full, b1_full, gap);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (FrameDone) break;
    end
    check("frame_done_seen", FrameDone, 1);
  endtask

  task automatic wait_read(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (readFrame) break;
    end
    check("read_started", readFrame, 1);
  endtask

  // ---------------- monitor ----------------
  int   mon_cyc, mon_incs, mon_reads, mon_cs, mon_gap;
  int   since_done = 0;
  bit   in_frame = 1'b0;
  bit   prev_frrl = 1'b0;
  exp_t got;

  always @(negedge clk) begin
    if (!reset) begin
      in_frame   = 1'b0;
      prev_frrl  = 1'b0;
      since_done = 0;
    end else begin
      since_done++;
      if (prev_frrl) check("read_after_resetline", readFrame, 1);
      if (BufDone) check("bufdone_with_framedone", FrameDone, 1);
      if (FrameReadResetLine) begin
        in_frame  = 1'b1;
        mon_cyc   = 0;
        mon_incs  = 0;
        mon_reads = 0;
        mon_cs    = 0;
        mon_gap   = since_done;
      end
      if (in_frame) begin
        mon_cyc++;
        mon_incs  += int'(FrameReadIncLine);
        mon_reads += int'(readFrame);
        mon_cs    += int'(CSDisplay);
      end
      if (FrameDone) begin
        n_bufdone += int'(BufDone);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: FrameDone with %0d frames outstanding, expected none", 0);
        end else begin
          got = exp_q.pop_front();
          check("frame_bufsel", BufSel, got.sel);
          check("frame_length", mon_cyc, got.len);
          check("frame_inc_lines", mon_incs, got.incs);
          check("frame_read_cycles", mon_reads, got.reads);
          check("frame_cs_cycles", mon_cs, got.cs);
          if (got.gap != 0) check("frame_gap", mon_gap, got.gap);
        end
        in_frame   = 1'b0;
        since_done = 0;
      end
      prev_frrl = FrameReadResetLine;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    repeat (3) @(negedge clk);
    check("rst_state", o_dbg_state, 0);
    check("rst_csdisplay", CSDisplay, 0);
    check("rst_readframe", readFrame, 0);
    check("rst_bufsel", BufSel, 0);
    check("rst_underrun", Underrun, 0);
    check("rst_cfgerr", CfgErr, 0);
    check("rst_framedone", FrameDone, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_state", o_dbg_state, 0);
    check("post_rst_pixel", PixelCnt, 0);

    // Zero active size: must flag and never leave IDLE.
    set_sizes(1, 1, 0, 5);
    Buf0Empty = 1'b0;
    Start = 1'b1;
    repeat (4) @(negedge clk);
    check("cfgerr_flag", CfgErr, 1);
    check("cfgerr_stays_idle", o_dbg_state, 0);
    check("cfgerr_no_cs", CSDisplay, 0);
    Start = 1'b0;
    @(negedge clk);

    // Large frame; Start dropped mid-frame so it must finish and then idle.
    issue(10, 10, 100, 100, 1'b1, 1'b0, 0);
    Start = 1'b1;
    wait_read(20);
    Start = 1'b0;
    wait_done(13000);
    @(negedge clk);
    check("idle_after_stop", o_dbg_state, 0);
    check("no_underrun_yet", Underrun, 0);

    // Back-to-back frames: both full first, then random buffer availability.
    issue_rand(1'b1, 1'b1, 0);
    Start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_done(400);
      if (k < 8) begin
        if (k == 1) issue_rand(1'b1, 1'b1, 2);
        else begin
          r = $urandom_range(1, 3);
          issue_rand(r[0], r[1], 2);
        end
      end
    end

    // Starve both buffers, then fill buffer 1 with a zero-blanking frame.
    set_sizes(0, 0, 4, 3);
    Buf0Empty = 1'b1;
    Buf1Empty = 1'b1;
    repeat (12) @(negedge clk);
    check("underrun_waits", o_dbg_state, 1);
    check("underrun_flag", Underrun, 1);
    issue(0, 0, 4, 3, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("load_after_fill", FrameReadResetLine, 1);
    Start = 1'b0;
    wait_done(50);
    @(negedge clk);
    check("underrun_sticky", Underrun, 1);

    // Asynchronous reset in the middle of an active line.
    set_sizes(2, 1, 8, 4);
    Buf0Empty = 1'b0;
    Buf1Empty = 1'b0;
    Start = 1'b1;
    wait_read(20);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_state", o_dbg_state, 0);
    check("abort_csdisplay", CSDisplay, 0);
    check("abort_readframe", readFrame, 0);
    check("abort_pixel", PixelCnt, 0);
    check("abort_underrun", Underrun, 0);
    check("abort_bufdone", BufDone, 0);
    Start = 1'b0;
    model_last_sel = 1;
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_idle", o_dbg_state, 0);

    // After reset, buffer 0 is preferred again when both are full.
    issue_rand(1'b1, 1'b1, 0);
    Start = 1'b1;
    wait_read(20);
    Start = 1'b0;
    wait_done(400);
    repeat (5) @(negedge clk);

    check("exp_q_drained", exp_q.size(), 0);
    check("bufdone_count", n_bufdone, n_issued);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
